// File: rtl/frontend_pkg.sv
// Shared types and defaults for the picoMIPS input front end.
package frontend_pkg;

  // Default debounce window, in clk cycles.
  localparam int unsigned DefDebCycles = 50000;

  // Button debounce FSM states.
  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StDebPress   = 2'd1,
    StPressed    = 2'd2,
    StDebRelease = 2'd3
  } fe_state_t;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low clear.
// ResetVal selects the cleared level so a synchronised active-low input can idle
// in its inactive state while reset is held.
module sync2 #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops give metastability a full cycle to resolve.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/input_frontend.sv
// Input conditioning for the picoMIPS CPU: synchronises and debounces the
// pushbutton and slide switches, producing readyin, x and a one-cycle press strobe.
// Optional feature macro: FRONTEND_SNAPSHOT_EN (x latches the switches on each
// accepted press instead of following them continuously).
module input_frontend
  import frontend_pkg::*;
#(
  parameter int unsigned n          = 8,
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_n,
  input  logic [n-1:0] sw,
  output logic         readyin,
  output logic [n-1:0] x,
  output logic         press
);

  localparam int unsigned     CNT_W  = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic         key_n_sync;
  logic         key_s;
  logic [n-1:0] sw_sync;

  fe_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             readyin_q, readyin_d;
  logic             press_q, press_d;

  // Key flops clear to "released" so reset never looks like a press.
  sync2 #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_sync_key (
    .clk    (clk),
    .nreset (nreset),
    .d      (key_n),
    .q      (key_n_sync)
  );

  sync2 #(
    .Width    (n),
    .ResetVal ('0)
  ) u_sync_sw (
    .clk    (clk),
    .nreset (nreset),
    .d      (sw),
    .q      (sw_sync)
  );

  assign key_s   = ~key_n_sync;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and counter logic of the debounce FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d = StDebPress;
          cnt_d   = '0;
        end
      end
      StDebPress: begin
        if (!key_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        if (!key_s) begin
          state_d = StDebRelease;
          cnt_d   = '0;
        end
      end
      StDebRelease: begin
        if (key_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the current state; registered so outputs come from flops.
  // PRESSED is only reached with readyin still low on the way in from DEB_PRESS,
  // so that combination marks the first cycle of an accepted press.
  always_comb begin
    readyin_d = (state_q == StPressed) || (state_q == StDebRelease);
    press_d   = (state_q == StPressed) && !readyin_q;
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      readyin_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      readyin_q <= readyin_d;
      press_q   <= press_d;
    end
  end

  assign readyin = readyin_q;
  assign press   = press_q;

`ifdef FRONTEND_SNAPSHOT_EN
  logic [n-1:0] x_q;

  // Capture the switches on the edge press rises; hold until the next press.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_q <= '0;
    end else if (press_d) begin
      x_q <= sw_sync;
    end
  end

  assign x = x_q;
`else
  assign x = sw_sync;
`endif

endmodule

// File: tb/tb_input_frontend.sv
// Directed self-checking bench for input_frontend with DEB_CYCLES=4, n=8.
// Inputs change 1 time unit after a rising edge; the next rising edge is the
// capture edge "t", and a clean press/release shows up 7 edges after that.
module tb_input_frontend;

  logic       clk;
  logic       nreset;
  logic       key_n;
  logic [7:0] sw;
  logic       readyin;
  logic [7:0] x;
  logic       press;

  int checks;
  int passes;

  input_frontend #(
    .n          (8),
    .DEB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .key_n   (key_n),
    .sw      (sw),
    .readyin (readyin),
    .x       (x),
    .press   (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance k rising edges and settle just after the last one.
  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else passes++;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    key_n  = 1'b0;
    sw     = 8'hFF;
    edges(3);
    chk1("reset_readyin", readyin, 1'b0);
    chk1("reset_press", press, 1'b0);
    chk8("reset_x", x, 8'h00);
    key_n  = 1'b1;
    sw     = 8'hA5;
    nreset = 1'b1;
    edges(4);
  endtask

  task automatic test_clean_press();
    key_n = 1'b0;
    edges(7);
    chk1("press_readyin_t6", readyin, 1'b0);
    chk1("press_strobe_t6", press, 1'b0);
    edges(1);
    chk1("press_readyin_t7", readyin, 1'b1);
    chk1("press_strobe_t7", press, 1'b1);
    chk8("press_x_t7", x, 8'hA5);
    edges(1);
    chk1("press_strobe_t8", press, 1'b0);
    chk1("press_readyin_t8", readyin, 1'b1);
    edges(3);
    // Clean release.
    key_n = 1'b1;
    edges(7);
    chk1("release_readyin_t6", readyin, 1'b1);
    edges(1);
    chk1("release_readyin_t7", readyin, 1'b0);
    edges(3);
  endtask

  task automatic test_bounce();
    logic seen_ready;
    logic seen_press;
    seen_ready = 1'b0;
    seen_press = 1'b0;
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      seen_ready |= readyin;
      seen_press |= press;
    end
    key_n = 1'b1;
    edges(1);
    seen_ready |= readyin;
    seen_press |= press;
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      seen_ready |= readyin;
      seen_press |= press;
    end
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      seen_ready |= readyin;
      seen_press |= press;
    end
    chk1("bounce_readyin_never", seen_ready, 1'b0);
    chk1("bounce_press_never", seen_press, 1'b0);
  endtask

  task automatic test_release_bounce();
    logic ready_dropped;
    logic extra_press;
    ready_dropped = 1'b0;
    extra_press   = 1'b0;
    key_n = 1'b0;
    edges(10);
    chk1("rb_pressed", readyin, 1'b1);
    key_n = 1'b1;
    edges(2);
    key_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      ready_dropped |= ~readyin;
      extra_press   |= press;
    end
    chk1("rb_readyin_held", ready_dropped, 1'b0);
    chk1("rb_no_second_press", extra_press, 1'b0);
    key_n = 1'b1;
    edges(7);
    chk1("rb_release_t6", readyin, 1'b1);
    edges(1);
    chk1("rb_release_t7", readyin, 1'b0);
    edges(3);
  endtask

  task automatic test_snapshot();
    sw = 8'h3C;
    edges(3);
    key_n = 1'b0;
    edges(8);
    chk1("snap_press", press, 1'b1);
    chk8("snap_capture", x, 8'h3C);
    edges(2);
    sw = 8'hC3;
    edges(1);
    chk8("snap_x_1edge", x, 8'h3C);
    edges(1);
`ifdef FRONTEND_SNAPSHOT_EN
    chk8("snap_x_held", x, 8'h3C);
    edges(5);
    chk8("snap_x_still_held", x, 8'h3C);
`else
    chk8("snap_x_follow", x, 8'hC3);
    edges(5);
    chk8("snap_x_still_follow", x, 8'hC3);
`endif
    key_n = 1'b1;
    edges(12);
    chk1("snap_released", readyin, 1'b0);
  endtask

  task automatic test_reset_mid_debounce();
    key_n = 1'b0;
    // Capture edge t plus four more: DEB_PRESS with cnt=2.
    edges(5);
    nreset = 1'b0;
    #1;
    chk1("rst_mid_readyin", readyin, 1'b0);
    chk1("rst_mid_press", press, 1'b0);
    edges(2);
    nreset = 1'b1;
    edges(7);
    chk1("rst_mid_relat_t6", readyin, 1'b0);
    edges(1);
    chk1("rst_mid_relat_t7", readyin, 1'b1);
    chk1("rst_mid_relat_press", press, 1'b1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    nreset = 1'b0;
    key_n  = 1'b1;
    sw     = 8'h00;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_snapshot();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
